// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline hazard controller.
// Imported by the controller top; holds FSM state codes and register-0 constant.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         MEM_TIMEOUT_DEF = 16;
  localparam int         CNT_W_DEF       = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard event inputs and stall/flush controls between datapath and controller.
// Purely combinational wiring; no handshake state lives here.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_pcsrc;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             freeze;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_pcsrc, dmem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, freeze, err,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, mem_pcsrc, dmem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, freeze, err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; 1-cycle update latency.
// Holds at all-ones once reached, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Mealy stall/flush sequencer for load-use, taken-branch and data-memory wait events.
// Controls are combinational from state+inputs; a memory wait freezes the whole pipeline.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        err_q;

  logic lu;
  logic mw;
  logic pc_write_c;
  logic if_id_write_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_flush_c;
  logic freeze_c;
  logic branch_evt;

  assign lu = bus.ex_mem_read && (bus.ex_rt != REG_ZERO) &&
              ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign mw = bus.dmem_req && !bus.dmem_ready;

  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    freeze_c       = 1'b0;
    branch_evt     = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (mw) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            freeze_c      = 1'b1;
          end else if (bus.mem_pcsrc) begin
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            branch_evt     = 1'b1;
          end else if (lu) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            id_ex_flush_c = 1'b1;
          end
        end
        // Release cycle: pipeline simply advances; branch/load-use wait for RUN.
        MEM_WAIT: begin
          if (!bus.dmem_ready) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            freeze_c      = 1'b1;
          end
        end
        default: begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          freeze_c      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TMO_LAST) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state <= ERR;
          err_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write_c;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_flush = ex_mem_flush_c;
  assign bus.freeze       = freeze_c;
  assign bus.err          = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!rst && !pc_write_c),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (rst),
    .en  (branch_evt),
    .cnt (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a queue of expected control vectors.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, freeze, err}
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] LU   = 7'b0001000;
  localparam logic [6:0] BR   = 7'b1111100;
  localparam logic [6:0] FRZ  = 7'b0000010;
  localparam logic [6:0] ERRF = 7'b0000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hif ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic pcs,
                        input logic req, input logic rdy);
    hif.ex_mem_read = mr;
    hif.ex_rt       = ert;
    hif.id_rs       = rs;
    hif.id_rt       = rt;
    hif.id_uses_rt  = urt;
    hif.mem_pcsrc   = pcs;
    hif.dmem_req    = req;
    hif.dmem_ready  = rdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push expectation, let the cycle settle, compare mid-cycle, then advance an edge.
  task automatic step(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush,
           hif.ex_mem_flush, hif.freeze, hif.err};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with hazards present: outputs forced, counters must not move.
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    step("rst_force", NORM);
    rst = 1'b0;
    idle();
    chk("rst_stall_cnt", hif.stall_cnt, 4'd0);
    chk("rst_flush_cnt", hif.flush_cnt, 4'd0);
    chk("rst_err", {3'b000, hif.err}, 4'd0);
    step("idle", NORM);

    // Load-use on rs, one bubble
    set_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rs", LU);
    idle();
    step("lu_done", NORM);
    chk("lu_stall_cnt", hif.stall_cnt, 4'd1);

    // Register 0 never stalls; rt only matters when used
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_reg0", NORM);
    set_in(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    step("lu_rt_unused", NORM);
    set_in(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_rt_used", LU);
    idle();
    chk("lu2_stall_cnt", hif.stall_cnt, 4'd2);

    // Taken branch
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("branch", BR);
    idle();
    step("branch_done", NORM);
    chk("br_flush_cnt", hif.flush_cnt, 4'd1);

    // Memory wait 3 cycles; branch pending on release is deferred one cycle
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      step("mw_freeze", FRZ);
    end
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("mw_release", NORM);
    chk("mw_stall_cnt", hif.stall_cnt, 4'd5);
    chk("mw_flush_defer", hif.flush_cnt, 4'd1);
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("mw_branch_after", BR);
    chk("mw_flush_cnt", hif.flush_cnt, 4'd2);

    // Branch beats load-use: no bubble, no stall count
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("prio_br_lu", BR);
    chk("prio_flush_cnt", hif.flush_cnt, 4'd3);
    chk("prio_stall_cnt", hif.stall_cnt, 4'd5);

    // Freeze beats branch
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    step("prio_mw_br", FRZ);
    chk("prio_mw_flush_cnt", hif.flush_cnt, 4'd3);
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    step("prio_release", NORM);
    chk("prio_rel_flush_cnt", hif.flush_cnt, 4'd3);
    chk("prio_rel_stall_cnt", hif.stall_cnt, 4'd6);
    idle();
    step("prio_idle", NORM);

    // Timeout: 4 wait cycles, then sticky error and permanent freeze
    for (int i = 0; i < TMO; i++) begin
      set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      step("tmo_wait", FRZ);
    end
    chk("tmo_stall_cnt", hif.stall_cnt, 4'd10);
    step("tmo_err", ERRF);
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step("err_hold", ERRF);
    end
    chk("stall_saturate", hif.stall_cnt, 4'd15);
    chk("err_flush_cnt", hif.flush_cnt, 4'd3);

    // One reset edge clears everything
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    chk("rst2_err", {3'b000, hif.err}, 4'd0);
    chk("rst2_stall_cnt", hif.stall_cnt, 4'd0);
    chk("rst2_flush_cnt", hif.flush_cnt, 4'd0);
    step("rst2_idle", NORM);

    // Reset in the middle of a wait returns to RUN, so a fresh wait does not time out early
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step("midrst_w1", FRZ);
    step("midrst_w2", FRZ);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("midrst_rewait", FRZ);
    end
    set_in(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    step("midrst_release", NORM);
    chk("midrst_stall_cnt", hif.stall_cnt, 4'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
